// File: rtl/ddram_arb.sv
// ddram_arb: two-client request arbiter in front of the DDRAM bridge.
// Optional macro DDRAM_ARB_RR_EN selects round-robin tie-breaking.
module ddram_arb #(
   parameter int GAP_CYCLES = 1,
   parameter bit A_PRIO     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [27:1] a_addr,
   input  logic [31:0] a_din,
   input  logic        a_rd,
   input  logic [3:0]  a_wr,
   input  logic        a_16b,
   output logic [31:0] a_dout,
   output logic        a_ack,
   output logic        a_busy,
   input  logic [27:1] b_addr,
   input  logic [31:0] b_din,
   input  logic        b_rd,
   input  logic [3:0]  b_wr,
   input  logic        b_16b,
   output logic [31:0] b_dout,
   output logic        b_ack,
   output logic        b_busy,
   output logic [27:1] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_rd,
   output logic [3:0]  mem_wr,
   output logic        mem_16b,
   input  logic [31:0] mem_dout,
   input  logic        mem_busy
);

   typedef enum logic [2:0] {
      S_DRAIN, S_GAP, S_IDLE, S_ISSUE, S_WBUSY, S_WDONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        gnt_q, gnt_d;
   logic [27:1] m_addr_q, m_addr_d;
   logic [31:0] m_din_q, m_din_d;
   logic        m_rd_q, m_rd_d;
   logic [3:0]  m_wr_q, m_wr_d;
   logic        m_16b_q, m_16b_d;
   logic        done;
   logic        prio_a;
   logic        g;

   logic [1:0]  in_rd, in_16b;
   logic [27:1] in_addr [2];
   logic [31:0] in_din [2];
   logic [3:0]  in_wr [2];

   logic [1:0]  pend_q, pend_d, busy_q, busy_d, ack_q, ack_d;
   logic [1:0]  kind_q, kind_d, b16_q, b16_d;
   logic [27:1] addr_q [2], addr_d [2];
   logic [31:0] din_q [2], din_d [2];
   logic [31:0] dout_q [2], dout_d [2];
   logic [3:0]  wr_q [2], wr_d [2];

   assign in_rd      = {b_rd, a_rd};
   assign in_16b     = {b_16b, a_16b};
   assign in_addr[0] = a_addr;
   assign in_addr[1] = b_addr;
   assign in_din[0]  = a_din;
   assign in_din[1]  = b_din;
   assign in_wr[0]   = a_wr;
   assign in_wr[1]   = b_wr;

   assign a_dout   = dout_q[0];
   assign b_dout   = dout_q[1];
   assign a_ack    = ack_q[0];
   assign b_ack    = ack_q[1];
   assign a_busy   = busy_q[0];
   assign b_busy   = busy_q[1];
   assign mem_addr = m_addr_q;
   assign mem_din  = m_din_q;
   assign mem_rd   = m_rd_q;
   assign mem_wr   = m_wr_q;
   assign mem_16b  = m_16b_q;

`ifdef DDRAM_ARB_RR_EN
   logic rr_q, rr_d, tie_q, tie_d;

   // remember whether the grant was a tie; prefer the other client next tie
   always_comb begin
      rr_d  = rr_q;
      tie_d = tie_q;
      if (state_q == S_IDLE && |pend_q) tie_d = &pend_q;
      if (done && tie_q) rr_d = ~gnt_q;
   end

   // round-robin preference register
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q  <= ~A_PRIO;
         tie_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         tie_q <= tie_d;
      end
   end

   assign prio_a = ~rr_q;
`else
   assign prio_a = A_PRIO;
`endif

   assign g = pend_q[1] & (~pend_q[0] | ~prio_a);

   // command sequencer: drain, gap, grant, issue, wait for bridge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      m_addr_d = m_addr_q;
      m_din_d  = m_din_q;
      m_rd_d   = m_rd_q;
      m_wr_d   = m_wr_q;
      m_16b_d  = m_16b_q;
      done     = 1'b0;
      unique case (state_q)
         S_DRAIN: begin
            if (!mem_busy) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q == 3'(GAP_CYCLES - 1)) state_d = S_IDLE;
            else cnt_d = cnt_q + 3'd1;
         end
         S_IDLE: begin
            if (|pend_q) begin
               gnt_d    = g;
               m_addr_d = addr_q[g];
               m_din_d  = din_q[g];
               m_16b_d  = b16_q[g];
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (kind_q[gnt_q]) m_wr_d = wr_q[gnt_q];
            else m_rd_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WBUSY;
         end
         S_WBUSY: begin
            if (mem_busy || cnt_q == 3'd1) state_d = S_WDONE;
            else cnt_d = cnt_q + 3'd1;
         end
         S_WDONE: begin
            if (!mem_busy) begin
               done    = 1'b1;
               m_rd_d  = 1'b0;
               m_wr_d  = 4'd0;
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         default: state_d = S_DRAIN;
      endcase
   end

   // sequencer and bridge command registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_DRAIN;
         cnt_q    <= '0;
         gnt_q    <= 1'b0;
         m_addr_q <= '0;
         m_din_q  <= '0;
         m_rd_q   <= 1'b0;
         m_wr_q   <= '0;
         m_16b_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         m_addr_q <= m_addr_d;
         m_din_q  <= m_din_d;
         m_rd_q   <= m_rd_d;
         m_wr_q   <= m_wr_d;
         m_16b_q  <= m_16b_d;
      end
   end

   // per-client strobe capture, completion and status
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         pend_d[i] = pend_q[i];
         busy_d[i] = busy_q[i];
         ack_d[i]  = 1'b0;
         kind_d[i] = kind_q[i];
         b16_d[i]  = b16_q[i];
         addr_d[i] = addr_q[i];
         din_d[i]  = din_q[i];
         wr_d[i]   = wr_q[i];
         dout_d[i] = dout_q[i];
         if (!busy_q[i] && (in_rd[i] || |in_wr[i])) begin
            pend_d[i] = 1'b1;
            busy_d[i] = 1'b1;
            kind_d[i] = |in_wr[i];
            b16_d[i]  = in_16b[i];
            addr_d[i] = in_addr[i];
            din_d[i]  = in_din[i];
            wr_d[i]   = in_wr[i];
         end
         if (ack_q[i]) busy_d[i] = 1'b0;
         if (done && gnt_q == 1'(i)) begin
            pend_d[i] = 1'b0;
            ack_d[i]  = 1'b1;
            if (!kind_q[i]) dout_d[i] = mem_dout;
         end
      end
   end

   // per-client registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         busy_q <= '0;
         ack_q  <= '0;
         kind_q <= '0;
         b16_q  <= '0;
         addr_q <= '{default: '0};
         din_q  <= '{default: '0};
         wr_q   <= '{default: '0};
         dout_q <= '{default: '0};
      end else begin
         pend_q <= pend_d;
         busy_q <= busy_d;
         ack_q  <= ack_d;
         kind_q <= kind_d;
         b16_q  <= b16_d;
         addr_q <= addr_d;
         din_q  <= din_d;
         wr_q   <= wr_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: scoreboard bench for ddram_arb with a behavioural
// bridge model that raises busy for a programmable number of cycles.
module tb_ddram_arb;

   localparam int GAP = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [27:1] a_addr = '0, b_addr = '0;
   logic [31:0] a_din = '0, b_din = '0;
   logic        a_rd = 1'b0, b_rd = 1'b0;
   logic [3:0]  a_wr = '0, b_wr = '0;
   logic        a_16b = 1'b0, b_16b = 1'b0;
   logic [31:0] a_dout, b_dout;
   logic        a_ack, b_ack, a_busy, b_busy;
   logic [27:1] mem_addr;
   logic [31:0] mem_din;
   logic        mem_rd;
   logic [3:0]  mem_wr;
   logic        mem_16b;
   logic [31:0] mem_dout = '0;
   logic        mem_busy = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ddram_arb #(.GAP_CYCLES(GAP), .A_PRIO(1'b1)) dut (
      .clk(clk), .reset(reset),
      .a_addr(a_addr), .a_din(a_din), .a_rd(a_rd), .a_wr(a_wr),
      .a_16b(a_16b), .a_dout(a_dout), .a_ack(a_ack), .a_busy(a_busy),
      .b_addr(b_addr), .b_din(b_din), .b_rd(b_rd), .b_wr(b_wr),
      .b_16b(b_16b), .b_dout(b_dout), .b_ack(b_ack), .b_busy(b_busy),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_16b(mem_16b),
      .mem_dout(mem_dout), .mem_busy(mem_busy)
   );

   function automatic logic [31:0] bdata(input logic [27:1] ad);
      if (ad == 27'h10) return 32'hDEADBEEF;
      return {5'h0, ad} ^ 32'h5A5A0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- bridge model ----------------
   int          busy_len = 6;
   int          bcnt = 0;
   logic        cmd_prev = 1'b0;
   int          rd_rises = 0, wr_rises = 0;
   int          low_run = 0, min_gap = 1000;
   bit          seen_cmd = 1'b0;
   int          stab_err = 0;
   logic [27:1] cap_addr = '0;
   logic [31:0] cap_din = '0;
   logic [3:0]  cap_wr = '0;
   logic        cap_rd = 1'b0, cap_16b = 1'b0;
   wire         cmd = mem_rd | (|mem_wr);

   always @(posedge clk) begin
      cmd_prev <= cmd;
      low_run  <= cmd ? 0 : low_run + 1;
      if (cmd && !cmd_prev) begin
         cap_addr <= mem_addr;
         cap_din  <= mem_din;
         cap_wr   <= mem_wr;
         cap_rd   <= mem_rd;
         cap_16b  <= mem_16b;
         if (mem_rd) rd_rises <= rd_rises + 1;
         else wr_rises <= wr_rises + 1;
         if (seen_cmd && low_run < min_gap) min_gap <= low_run;
         seen_cmd <= 1'b1;
         if (busy_len == 0) begin
            if (mem_rd) mem_dout <= bdata(mem_addr);
         end else begin
            mem_busy <= 1'b1;
            bcnt     <= busy_len;
         end
      end else if (mem_busy) begin
         if (cmd && (mem_addr !== cap_addr || mem_din !== cap_din ||
                     mem_wr !== cap_wr || mem_rd !== cap_rd ||
                     mem_16b !== cap_16b))
            stab_err <= stab_err + 1;
         if (bcnt == 1) begin
            mem_busy <= 1'b0;
            if (cap_rd) mem_dout <= bdata(mem_addr);
         end
         bcnt <= bcnt - 1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        cl;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_dout [2] = '{32'h0, 32'h0};
   logic        prev_a_ack = 1'b0, prev_b_ack = 1'b0;

   task automatic check_ack(input logic cl, input logic [31:0] dout);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL unexpected_ack: client %0d got ack, none expected", cl);
         return;
      end
      e = sb.pop_front();
      if (e.cl !== cl) begin
         failures++;
         $display("FAIL grant_order: got ack client %0d expected %0d", cl, e.cl);
         return;
      end
      if (e.rd) exp_dout[cl] = e.data;
      if (dout !== exp_dout[cl]) begin
         failures++;
         $display("FAIL dout: client %0d got %h expected %h",
                  cl, dout, exp_dout[cl]);
      end
   endtask

   always @(negedge clk) begin
      if (prev_a_ack) chk("a_busy_after_ack", 32'(a_busy), 32'h0);
      if (prev_b_ack) chk("b_busy_after_ack", 32'(b_busy), 32'h0);
      prev_a_ack = a_ack;
      prev_b_ack = b_ack;
      if (a_ack) check_ack(1'b0, a_dout);
      if (b_ack) check_ack(1'b1, b_dout);
   end

   // ---------------- stimulus ----------------
   task automatic set_a(input logic rd, input logic [3:0] wr,
                        input logic [27:1] ad, input logic [31:0] d,
                        input logic h);
      a_rd = rd; a_wr = wr; a_addr = ad; a_din = d; a_16b = h;
   endtask

   task automatic set_b(input logic rd, input logic [3:0] wr,
                        input logic [27:1] ad, input logic [31:0] d,
                        input logic h);
      b_rd = rd; b_wr = wr; b_addr = ad; b_din = d; b_16b = h;
   endtask

   task automatic clr();
      a_rd = 1'b0; a_wr = '0;
      b_rd = 1'b0; b_wr = '0;
   endtask

   task automatic push(input logic cl, input logic rd,
                       input logic [31:0] d);
      exp_t e;
      e.cl = cl; e.rd = rd; e.data = d;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while ((sb.size() != 0 || a_busy || b_busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         failures++;
         $display("FAIL %s_timeout: pending=%0d after %0d cycles, required 0",
                  nm, sb.size(), n);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   int r0;
   int n;
   bit bfirst;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_a_ack", 32'(a_ack), 32'h0);
      chk("rst_a_busy", 32'(a_busy), 32'h0);
      chk("rst_a_dout", a_dout, 32'h0);
      chk("rst_b_ack", 32'(b_ack), 32'h0);
      chk("rst_b_busy", 32'(b_busy), 32'h0);
      chk("rst_b_dout", b_dout, 32'h0);
      chk("rst_mem_rd", 32'(mem_rd), 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_din", mem_din, 32'h0);
      chk("rst_mem_16b", 32'(mem_16b), 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // A read, 6-cycle busy; a second strobe while busy is ignored
      busy_len = 6;
      r0 = rd_rises;
      set_a(1'b1, 4'h0, 27'h10, 32'h0, 1'b0);
      push(1'b0, 1'b1, 32'hDEADBEEF);
      @(negedge clk); clr();
      @(negedge clk);
      set_a(1'b1, 4'h0, 27'h77, 32'h0, 1'b0);
      @(negedge clk); clr();
      wait_done("a_read");
      chk("a_read_rd_rises", 32'(rd_rises - r0), 32'h1);

      // B 16-bit write
      r0 = wr_rises;
      set_b(1'b0, 4'b0011, 27'h6, 32'hABCD1234, 1'b1);
      push(1'b1, 1'b0, 32'h0);
      @(negedge clk); clr();
      wait_done("b_write");
      chk("b_write_wr_rises", 32'(wr_rises - r0), 32'h1);
      chk("b_write_mem_wr", 32'(cap_wr), 32'h3);
      chk("b_write_mem_16b", 32'(cap_16b), 32'h1);
      chk("b_write_mem_din", 32'(cap_din[15:0]), 32'h1234);
      chk("b_write_mem_addr", 32'(cap_addr), 32'h6);

      // simultaneous strobes, repeated four times
      for (int r = 0; r < 4; r++) begin
`ifdef DDRAM_ARB_RR_EN
         bfirst = (r % 2 == 1);
`else
         bfirst = 1'b0;
`endif
         set_a(1'b1, 4'h0, 27'(32'h100 + r), 32'h0, 1'b0);
         set_b(1'b1, 4'h0, 27'(32'h200 + r), 32'h0, 1'b0);
         if (bfirst) begin
            push(1'b1, 1'b1, bdata(27'(32'h200 + r)));
            push(1'b0, 1'b1, bdata(27'(32'h100 + r)));
         end else begin
            push(1'b0, 1'b1, bdata(27'(32'h100 + r)));
            push(1'b1, 1'b1, bdata(27'(32'h200 + r)));
         end
         @(negedge clk); clr();
         wait_done("tie");
      end

      // cache hit: busy never rises
      busy_len = 0;
      set_a(1'b1, 4'h0, 27'h300, 32'h0, 1'b0);
      push(1'b0, 1'b1, bdata(27'h300));
      @(negedge clk); clr();
      wait_done("cache_hit");

      // reset in the middle of a long write
      busy_len = 20;
      set_b(1'b0, 4'hF, 27'h40, 32'h11223344, 1'b0);
      @(negedge clk); clr();
      n = 0;
      while (!mem_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_busy_seen", 32'(mem_busy), 32'h1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_mid_b_busy", 32'(b_busy), 32'h0);
      r0 = rd_rises + wr_rises;
      set_a(1'b1, 4'h0, 27'h50, 32'h0, 1'b0);
      push(1'b0, 1'b1, bdata(27'h50));
      @(negedge clk); clr();
      n = 0;
      while (mem_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_no_issue", 32'(rd_rises + wr_rises - r0), 32'h0);
      chk("drain_busy_fell", 32'(mem_busy), 32'h0);
      wait_done("after_reset");
      chk("after_reset_rises", 32'(rd_rises + wr_rises - r0), 32'h1);

      checks++;
      if (min_gap < GAP) begin
         failures++;
         $display("FAIL min_gap: got %0d required >= %0d", min_gap, GAP);
      end
      chk("cmd_stability", 32'(stab_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
